// File: rtl/rollcall_match_drain.sv
// rollcall_match_drain
// Captures one 4-bit match vector and streams out the index of every set bit
// (with its wrap-around seat pair) over a valid/ready handshake, then pulses
// DONE once the capture has fully drained. COUNT reports the population count
// of the captured vector and holds until the next accepted capture.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for START; MATCH_IN is captured when START is seen
// EMIT    | presenting the selected pending index; cleared on each handshake
// DONE    | one-cycle completion pulse, then back to IDLE

module rollcall_match_drain #(
  parameter bit DESCEND = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] MATCH_IN,
  input  logic       OUT_READY,
  output logic       BUSY,
  output logic       OUT_VALID,
  output logic [1:0] OUT_IDX,
  output logic [1:0] OUT_SEAT_B,
  output logic       OUT_LAST,
  output logic [2:0] COUNT,
  output logic       DONE
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [2:0] count_q;
  logic [2:0] count_nxt;

  logic [1:0] sel_idx;
  logic [3:0] sel_mask;
  logic       pend_one;
  logic       xfer;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Pick the next index to present: lowest pending bit, or highest when DESCEND.
  // The loop order makes the last assignment the winning one.
  always_comb begin
    sel_idx = 2'd0;
    if (DESCEND) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) sel_idx = i[1:0];
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (pend[i]) sel_idx = i[1:0];
      end
    end
  end

  // Decode helpers: one-hot of the selected bit, single-bit-left flag, handshake.
  always_comb begin
    sel_mask = 4'b0001 << sel_idx;
    pend_one = (pend != 4'd0) && ((pend & (pend - 4'd1)) == 4'd0);
    xfer     = (state == ST_EMIT) && OUT_READY;
  end

  // Next-state logic; illegal encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    count_nxt = count_q;
    case (state)
      ST_IDLE: begin
        if (START) begin
          pend_nxt  = MATCH_IN;
          count_nxt = popcnt4(MATCH_IN);
          state_nxt = (MATCH_IN != 4'd0) ? ST_EMIT : ST_DONE;
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          pend_nxt = pend & ~sel_mask;
          if (pend_one) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        pend_nxt  = 4'd0;
      end
    endcase
  end

  // State registers; reset discards pending items and clears the reported count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      pend    <= 4'd0;
      count_q <= 3'd0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      count_q <= count_nxt;
    end
  end

  // Outputs decode registered state only; item fields are forced to 0 when not valid.
  always_comb begin
    OUT_VALID  = (state == ST_EMIT);
    BUSY       = (state == ST_EMIT) || (state == ST_DONE);
    DONE       = (state == ST_DONE);
    COUNT      = count_q;
    OUT_IDX    = OUT_VALID ? sel_idx : 2'd0;
    OUT_SEAT_B = OUT_VALID ? (sel_idx + 2'd1) : 2'd0;
    OUT_LAST   = OUT_VALID && pend_one;
  end

endmodule

// File: tb/tb_rollcall_match_drain.sv
// Bench for rollcall_match_drain: ascending and descending instances share all
// inputs; expected items come from per-capture queues built from the match bits.

module tb_rollcall_match_drain;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] match_in;
  logic       out_ready;

  logic       a_busy, a_valid, a_last, a_done;
  logic [1:0] a_idx, a_seat;
  logic [2:0] a_count;
  logic       d_busy, d_valid, d_last, d_done;
  logic [1:0] d_idx, d_seat;
  logic [2:0] d_count;

  int n_tests = 0;
  int n_fail  = 0;

  rollcall_match_drain #(.DESCEND(1'b0)) dut_asc (
    .CLK(clk), .RST(rst), .START(start), .MATCH_IN(match_in), .OUT_READY(out_ready),
    .BUSY(a_busy), .OUT_VALID(a_valid), .OUT_IDX(a_idx), .OUT_SEAT_B(a_seat),
    .OUT_LAST(a_last), .COUNT(a_count), .DONE(a_done)
  );

  rollcall_match_drain #(.DESCEND(1'b1)) dut_dsc (
    .CLK(clk), .RST(rst), .START(start), .MATCH_IN(match_in), .OUT_READY(out_ready),
    .BUSY(d_busy), .OUT_VALID(d_valid), .OUT_IDX(d_idx), .OUT_SEAT_B(d_seat),
    .OUT_LAST(d_last), .COUNT(d_count), .DONE(d_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both instances outside EMIT/DONE: everything 0 except the held count.
  task automatic check_idle(input string tag, input int cnt);
    chk({tag, "_busy_a"},  a_busy,  0);
    chk({tag, "_valid_a"}, a_valid, 0);
    chk({tag, "_idx_a"},   a_idx,   0);
    chk({tag, "_seat_a"},  a_seat,  0);
    chk({tag, "_last_a"},  a_last,  0);
    chk({tag, "_done_a"},  a_done,  0);
    chk({tag, "_count_a"}, a_count, cnt);
    chk({tag, "_busy_d"},  d_busy,  0);
    chk({tag, "_valid_d"}, d_valid, 0);
    chk({tag, "_done_d"},  d_done,  0);
    chk({tag, "_count_d"}, d_count, cnt);
  endtask

  // One capture from IDLE through DONE and back to IDLE. Ready comes from
  // pat (bit per presented cycle) or randomly; disturb toggles START/MATCH_IN mid-drain.
  task automatic do_capture(input logic [3:0] m, input bit use_pat, input logic [15:0] pat,
                            input int pct, input bit disturb);
    int qa[$];
    int qd[$];
    int n;
    int steps;
    bit rdy;
    for (int i = 0; i < 4; i++) if (m[i]) qa.push_back(i);
    for (int i = 3; i >= 0; i--) if (m[i]) qd.push_back(i);
    n = qa.size();
    start     = 1'b1;
    match_in  = m;
    out_ready = 1'($urandom_range(1));
    tick();
    start = 1'b0;
    steps = 0;
    while (qa.size() > 0 && steps < 64) begin
      chk("emit_valid_a", a_valid, 1);
      chk("emit_busy_a",  a_busy,  1);
      chk("emit_done_a",  a_done,  0);
      chk("emit_idx_a",   a_idx,   qa[0]);
      chk("emit_seat_a",  a_seat,  (qa[0] + 1) % 4);
      chk("emit_last_a",  a_last,  (qa.size() == 1) ? 1 : 0);
      chk("emit_count_a", a_count, n);
      chk("emit_valid_d", d_valid, 1);
      chk("emit_idx_d",   d_idx,   qd[0]);
      chk("emit_seat_d",  d_seat,  (qd[0] + 1) % 4);
      chk("emit_last_d",  d_last,  (qd.size() == 1) ? 1 : 0);
      chk("emit_count_d", d_count, n);
      rdy = use_pat ? pat[steps[3:0]] : ($urandom_range(99) < pct);
      out_ready = rdy;
      if (disturb) begin
        match_in = 4'($urandom_range(15));
        start    = 1'($urandom_range(1));
      end
      tick();
      if (rdy) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      steps++;
    end
    if (qa.size() > 0) chk("drain_timeout", qa.size(), 0);
    start = 1'b0;
    chk("done_pulse_a", a_done,  1);
    chk("done_busy_a",  a_busy,  1);
    chk("done_valid_a", a_valid, 0);
    chk("done_idx_a",   a_idx,   0);
    chk("done_last_a",  a_last,  0);
    chk("done_count_a", a_count, n);
    chk("done_pulse_d", d_done,  1);
    chk("done_valid_d", d_valid, 0);
    chk("done_count_d", d_count, n);
    tick();
    check_idle("post", n);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    match_in  = 4'b1111;
    out_ready = 1'b0;

    // Reset held with START and a full match vector.
    tick();
    check_idle("rst1", 0);
    tick();
    check_idle("rst2", 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_idle("rst_rel", 0);

    // Ascending drain of 1010 with ready high: 1 then 3, DONE in cycle 3.
    do_capture(4'b1010, 1'b1, 16'hFFFF, 100, 1'b0);

    // Empty capture.
    do_capture(4'b0000, 1'b1, 16'hFFFF, 100, 1'b0);

    // Backpressure: accept idx 0, then hold idx 1 for 3 cycles.
    do_capture(4'b1111, 1'b1, 16'b1111_1111_1111_0001, 100, 1'b0);

    // Descending order with START/MATCH_IN churn mid-drain.
    do_capture(4'b0101, 1'b1, 16'hFFFF, 100, 1'b1);

    // Reset after the first transfer of 0111.
    start     = 1'b1;
    match_in  = 4'b0111;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("mr_idx0_a", a_idx, 0);
    chk("mr_idx0_d", d_idx, 2);
    tick();
    chk("mr_valid1_a", a_valid, 1);
    chk("mr_idx1_a",   a_idx,   1);
    chk("mr_idx1_d",   d_idx,   1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mr_rst", 0);
    tick();
    check_idle("mr_after", 0);
    do_capture(4'b1000, 1'b1, 16'hFFFF, 100, 1'b0);

    // START held high through DONE re-arms an empty capture.
    start    = 1'b1;
    match_in = 4'b0000;
    tick();
    chk("hold_done1_a", a_done, 1);
    chk("hold_done1_d", d_done, 1);
    tick();
    chk("hold_idle_busy_a", a_busy, 0);
    chk("hold_idle_done_a", a_done, 0);
    tick();
    chk("hold_done2_a", a_done, 1);
    chk("hold_done2_d", d_done, 1);
    start = 1'b0;
    tick();
    check_idle("hold_end", 0);

    // Randomised captures.
    for (int t = 0; t < 60; t++) begin
      do_capture(4'($urandom_range(15)), 1'b0, 16'h0000,
                 int'($urandom_range(100, 30)), 1'($urandom_range(1)));
      if ($urandom_range(1) == 1) begin
        match_in  = 4'($urandom_range(15));
        out_ready = 1'($urandom_range(1));
        tick();
        chk("rand_gap_busy_a", a_busy, 0);
        chk("rand_gap_busy_d", d_busy, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
